reg_file_pipe: RTL and testbench

//  Clocked, parametrised CPU register file. Provides two registered read ports and two write ports:
//  an ALU writeback port and a memory-load writeback port.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 68 ++++++
 rtl/reg_file_pipe.sv | 116 +++++++++++
 tb/tb_reg_file_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and constants for decode, writeback and the
// register file itself. Widths here match the default register file build.
package rf_pkg;

    localparam int RF_DATA_W   = 8;
    localparam int RF_NUM_REGS = 16;
    localparam int RF_IDX_W    = $clog2(RF_NUM_REGS);

    // Index of the optional hard-wired zero register.
    localparam int ZERO_IDX = 0;

    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_IDX_W-1:0]  rf_idx_t;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Per-register load scoreboard: one busy flop per register, set when a load
// is issued and cleared when its data writes back. A load landing this cycle
// is forwarded by the register file bypass, so it is not reported busy.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sb_set_i,
    input  logic [IDX_W-1:0] sb_addr_i,
    input  logic             clr_i,
    input  logic [IDX_W-1:0] clr_addr_i,
    input  logic [IDX_W-1:0] look_addr1_i,
    input  logic [IDX_W-1:0] look_addr2_i,
    output logic             busy1_o,
    output logic             busy2_o
);

    localparam int              VEC_W = 1 << IDX_W;
    localparam logic [IDX_W:0]  LIMIT = (IDX_W + 1)'(NUM_REGS);

    function automatic logic in_range(input logic [IDX_W-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [VEC_W-1:0]    busy_vec;
    logic                set_ok;
    logic                clr_ok;

    // Next busy vector: clear on load writeback, then set on issue so a
    // reissued load to the same register keeps it busy.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        busy_d = busy_q;
        set_ok = sb_set_i && in_range(sb_addr_i) &&
                 !(ZERO_REG && (sb_addr_i == IDX_W'(ZERO_IDX)));
        clr_ok = clr_i && in_range(clr_addr_i);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_ok && (clr_addr_i == IDX_W'(i))) busy_d[i] = 1'b0;
            if (set_ok && (sb_addr_i == IDX_W'(i)))  busy_d[i] = 1'b1;
        end
    end

    // Busy flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            busy_q <= busy_d;
        end
    end

    // Busy lookups, widened to the full index space so out-of-range reads see 0.
    always_comb begin
        busy_vec                 = '0;
        busy_vec[NUM_REGS-1:0]   = busy_q;
        busy1_o = busy_vec[look_addr1_i] & ~(clr_i & (clr_addr_i == look_addr1_i));
        busy2_o = busy_vec[look_addr2_i] & ~(clr_i & (clr_addr_i == look_addr2_i));
    end

endmodule : rf_scoreboard

// File: rtl/reg_file_pipe.sv
// Pipelined CPU register file: two registered read ports with write-to-read
// bypass, ALU and load writeback ports (ALU wins on collision), an optional
// hard-wired zero register and a per-register load scoreboard.
module reg_file_pipe
    import rf_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr1,
    input  logic [IDX_W-1:0]  rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_valid,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              alu_we,
    input  logic [IDX_W-1:0]  alu_waddr,
    input  logic [DATA_W-1:0] alu_wdata,
    input  logic              ld_we,
    input  logic [IDX_W-1:0]  ld_waddr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              sb_set,
    input  logic [IDX_W-1:0]  sb_addr
);

    localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(NUM_REGS);

    // A write index is usable when it exists and is not the hard-wired zero.
    function automatic logic writable(input logic [IDX_W-1:0] a);
        return ({1'b0, a} < LIMIT) && !(ZERO_REG && (a == IDX_W'(ZERO_IDX)));
    endfunction

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
    logic              rd_valid_q;
    logic              alu_ok;
    logic              ld_ok;

    // Write-priority mux: load data first, ALU data overrides on the same index.
    always_comb begin
        regs_d = regs_q;
        alu_ok = alu_we && writable(alu_waddr);
        ld_ok  = ld_we && writable(ld_waddr);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ld_ok && (ld_waddr == IDX_W'(i)))   regs_d[i] = ld_wdata;
            if (alu_ok && (alu_waddr == IDX_W'(i))) regs_d[i] = alu_wdata;
        end
    end

    // Bypass mux: reads see the post-write value; unknown indices read 0.
    always_comb begin
        rd_data1_d = rd_data1_q;
        rd_data2_d = rd_data2_q;
        if (rd_en) begin
            rd_data1_d = '0;
            rd_data2_d = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_addr1 == IDX_W'(i)) rd_data1_d = regs_d[i];
                if (rd_addr2 == IDX_W'(i)) rd_data2_d = regs_d[i];
            end
        end
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage array is reset because all registers must read 0 right after reset.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read-output flops and the read-valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            rd_valid_q <= rd_en;
        end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
    assign rd_valid = rd_valid_q;

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .sb_set_i     (sb_set),
        .sb_addr_i    (sb_addr),
        .clr_i        (ld_we),
        .clr_addr_i   (ld_waddr),
        .look_addr1_i (rd_addr1),
        .look_addr2_i (rd_addr2),
        .busy1_o      (rd_busy1),
        .busy2_o      (rd_busy2)
    );

endmodule : reg_file_pipe

// File: tb/tb_reg_file_pipe.sv
// Directed bench for reg_file_pipe: default build with zero register, a build
// without it (sharing stimulus), and a 32-bit, 12-entry build.
module tb_reg_file_pipe;
    import rf_pkg::*;

    localparam int W2 = 32;
    localparam int N2 = 12;
    localparam int I2 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two 8-bit x 16 builds.
    logic     rd_en, alu_we, ld_we, sb_set;
    rf_idx_t  rd_addr1, rd_addr2, alu_waddr, ld_waddr, sb_addr;
    rf_data_t alu_wdata, ld_wdata;

    rf_data_t z_d1, z_d2, n_d1, n_d2;
    logic     z_v, z_b1, z_b2, n_v, n_b1, n_b2;

    // Stimulus for the 32-bit x 12 build.
    logic          b_rd_en, b_alu_we, b_ld_we, b_sb_set;
    logic [I2-1:0] b_rd_addr1, b_rd_addr2, b_alu_waddr, b_ld_waddr, b_sb_addr;
    logic [W2-1:0] b_alu_wdata, b_ld_wdata, b_d1, b_d2;
    logic          b_v, b_b1, b_b2;

    reg_file_pipe #(.DATA_W(8), .NUM_REGS(16), .ZERO_REG(1'b1)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(z_d1), .rd_data2(z_d2), .rd_valid(z_v), .rd_busy1(z_b1), .rd_busy2(z_b2),
        .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .ld_we(ld_we), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
        .sb_set(sb_set), .sb_addr(sb_addr)
    );

    reg_file_pipe #(.DATA_W(8), .NUM_REGS(16), .ZERO_REG(1'b0)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(n_d1), .rd_data2(n_d2), .rd_valid(n_v), .rd_busy1(n_b1), .rd_busy2(n_b2),
        .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .ld_we(ld_we), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
        .sb_set(sb_set), .sb_addr(sb_addr)
    );

    reg_file_pipe #(.DATA_W(W2), .NUM_REGS(N2), .ZERO_REG(1'b1)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .rd_en(b_rd_en), .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2),
        .rd_data1(b_d1), .rd_data2(b_d2), .rd_valid(b_v), .rd_busy1(b_b1), .rd_busy2(b_b2),
        .alu_we(b_alu_we), .alu_waddr(b_alu_waddr), .alu_wdata(b_alu_wdata),
        .ld_we(b_ld_we), .ld_waddr(b_ld_waddr), .ld_wdata(b_ld_wdata),
        .sb_set(b_sb_set), .sb_addr(b_sb_addr)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference contents of the 32-bit build.
    logic [W2-1:0] model [N2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_a();
        rd_en = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        alu_we = 1'b0; alu_waddr = '0; alu_wdata = '0;
        ld_we = 1'b0; ld_waddr = '0; ld_wdata = '0;
        sb_set = 1'b0; sb_addr = '0;
    endtask

    task automatic idle_b();
        b_rd_en = 1'b0; b_rd_addr1 = '0; b_rd_addr2 = '0;
        b_alu_we = 1'b0; b_alu_waddr = '0; b_alu_wdata = '0;
        b_ld_we = 1'b0; b_ld_waddr = '0; b_ld_wdata = '0;
        b_sb_set = 1'b0; b_sb_addr = '0;
    endtask

    // Expected read value of the 32-bit build for the inputs currently driven.
    function automatic logic [W2-1:0] model_read(input logic [I2-1:0] a);
        if (int'(a) >= N2 || a == '0)              return '0;
        if (b_alu_we && b_alu_waddr == a)          return b_alu_wdata;
        if (b_ld_we && b_ld_waddr == a)            return b_ld_wdata;
        return model[a];
    endfunction

    task automatic model_write();
        if (b_ld_we && int'(b_ld_waddr) < N2 && b_ld_waddr != '0)    model[b_ld_waddr] = b_ld_wdata;
        if (b_alu_we && int'(b_alu_waddr) < N2 && b_alu_waddr != '0) model[b_alu_waddr] = b_alu_wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W2-1:0] e1, e2;
        for (int i = 0; i < N2; i++) model[i] = '0;
        idle_a();
        idle_b();
        rst_n = 1'b0;
        #1;
        check("reset_d1", 32'(z_d1), 32'h0);
        check("reset_valid", 32'(z_v), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload, then pulse reset mid-cycle.
        alu_we = 1'b1; alu_waddr = 4'd1; alu_wdata = 8'h5A;
        ld_we = 1'b1; ld_waddr = 4'd2; ld_wdata = 8'h3C;
        sb_set = 1'b1; sb_addr = 4'd4;
        cyc();
        idle_a();
        rd_en = 1'b1; rd_addr1 = 4'd1; rd_addr2 = 4'd2;
        cyc();
        check("pre_z_d1", 32'(z_d1), 32'h5A);
        check("pre_z_d2", 32'(z_d2), 32'h3C);
        check("pre_n_d1", 32'(n_d1), 32'h5A);
        check("pre_valid", 32'(z_v), 32'h1);
        idle_a();
        rd_addr1 = 4'd4;
        #1;
        check("pre_busy4", 32'(z_b1), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_z_d1", 32'(z_d1), 32'h0);
        check("rst_z_d2", 32'(z_d2), 32'h0);
        check("rst_valid", 32'(z_v), 32'h0);
        check("rst_busy4", 32'(z_b1), 32'h0);
        check("rst_n_d1", 32'(n_d1), 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(z_v), 32'h0);
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_addr1 = 4'(i); rd_addr2 = 4'(15 - i);
            cyc();
            check($sformatf("clr_z_d1_r%0d", i), 32'(z_d1), 32'h0);
            check($sformatf("clr_z_d2_r%0d", 15 - i), 32'(z_d2), 32'h0);
            check($sformatf("clr_n_d1_r%0d", i), 32'(n_d1), 32'h0);
        end

        // Basic write then read.
        idle_a();
        alu_we = 1'b1; alu_waddr = 4'd3; alu_wdata = 8'hA5;
        cyc();
        idle_a();
        rd_en = 1'b1; rd_addr1 = 4'd3;
        cyc();
        check("wr_rd_d1", 32'(z_d1), 32'hA5);
        check("wr_rd_valid", 32'(z_v), 32'h1);
        idle_a();
        cyc();
        check("hold_valid", 32'(z_v), 32'h0);
        check("hold_d1", 32'(z_d1), 32'hA5);

        // Bypass and write collision.
        alu_we = 1'b1; alu_waddr = 4'd5; alu_wdata = 8'h11;
        ld_we = 1'b1; ld_waddr = 4'd5; ld_wdata = 8'h22;
        rd_en = 1'b1; rd_addr1 = 4'd5;
        cyc();
        check("coll_byp_d1", 32'(z_d1), 32'h11);
        idle_a();
        ld_we = 1'b1; ld_waddr = 4'd6; ld_wdata = 8'h33;
        rd_en = 1'b1; rd_addr1 = 4'd5; rd_addr2 = 4'd6;
        cyc();
        check("coll_stored_d1", 32'(z_d1), 32'h11);
        check("ld_byp_d2", 32'(z_d2), 32'h33);
        idle_a();
        alu_we = 1'b1; alu_waddr = 4'd9; alu_wdata = 8'h99;
        ld_we = 1'b1; ld_waddr = 4'd10; ld_wdata = 8'hAA;
        rd_en = 1'b1; rd_addr1 = 4'd9; rd_addr2 = 4'd10;
        cyc();
        check("dual_byp_d1", 32'(z_d1), 32'h99);
        check("dual_byp_d2", 32'(z_d2), 32'hAA);
        idle_a();
        rd_en = 1'b1; rd_addr1 = 4'd10; rd_addr2 = 4'd9;
        cyc();
        check("dual_st_d1", 32'(z_d1), 32'hAA);
        check("dual_st_d2", 32'(z_d2), 32'h99);

        // Zero register against an ordinary register 0.
        idle_a();
        alu_we = 1'b1; alu_waddr = 4'd0; alu_wdata = 8'hFF;
        sb_set = 1'b1; sb_addr = 4'd0;
        rd_en = 1'b1; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
        cyc();
        check("zero_byp_z_d1", 32'(z_d1), 32'h00);
        check("zero_byp_z_d2", 32'(z_d2), 32'h00);
        check("zero_byp_n_d1", 32'(n_d1), 32'hFF);
        idle_a();
        rd_en = 1'b1; rd_addr1 = 4'd0;
        #1;
        check("zero_busy_z", 32'(z_b1), 32'h0);
        check("zero_busy_n", 32'(n_b1), 32'h1);
        cyc();
        check("zero_st_z_d1", 32'(z_d1), 32'h00);
        check("zero_st_n_d1", 32'(n_d1), 32'hFF);
        idle_a();
        ld_we = 1'b1; ld_waddr = 4'd0; ld_wdata = 8'h12;
        rd_en = 1'b1; rd_addr1 = 4'd0;
        #1;
        check("zero_land_n_busy", 32'(n_b1), 32'h0);
        cyc();
        check("zero_ld_z_d1", 32'(z_d1), 32'h00);
        check("zero_ld_n_d1", 32'(n_d1), 32'h12);
        idle_a();
        #1;
        check("zero_clr_n_busy", 32'(n_b1), 32'h0);

        // Scoreboard set, landing-load forwarding, set/clear collision.
        idle_a();
        sb_set = 1'b1; sb_addr = 4'd7;
        cyc();
        idle_a();
        rd_addr1 = 4'd7; rd_addr2 = 4'd7;
        #1;
        check("sb_busy1", 32'(z_b1), 32'h1);
        check("sb_busy2", 32'(z_b2), 32'h1);
        ld_we = 1'b1; ld_waddr = 4'd7; ld_wdata = 8'h44;
        rd_en = 1'b1;
        #1;
        check("sb_land_busy1", 32'(z_b1), 32'h0);
        check("sb_land_busy2", 32'(z_b2), 32'h0);
        cyc();
        check("sb_land_d1", 32'(z_d1), 32'h44);
        idle_a();
        rd_addr1 = 4'd7;
        #1;
        check("sb_cleared", 32'(z_b1), 32'h0);
        sb_set = 1'b1; sb_addr = 4'd7;
        ld_we = 1'b1; ld_waddr = 4'd7; ld_wdata = 8'h55;
        cyc();
        idle_a();
        rd_addr1 = 4'd7;
        #1;
        check("sb_set_wins", 32'(z_b1), 32'h1);
        alu_we = 1'b1; alu_waddr = 4'd7; alu_wdata = 8'h66;
        cyc();
        idle_a();
        rd_addr1 = 4'd7;
        #1;
        check("sb_alu_no_clr", 32'(z_b1), 32'h1);
        ld_we = 1'b1; ld_waddr = 4'd7; ld_wdata = 8'h77;
        rd_en = 1'b1;
        cyc();
        check("sb_final_d1", 32'(z_d1), 32'h77);
        idle_a();
        rd_addr1 = 4'd7;
        #1;
        check("sb_final_busy", 32'(z_b1), 32'h0);

        // 32-bit, 12-entry build: randomised traffic against the model.
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            b_alu_we    = 1'($urandom_range(0, 1));
            b_alu_waddr = I2'($urandom_range(0, 15));
            b_alu_wdata = $urandom;
            b_ld_we     = 1'($urandom_range(0, 1));
            b_ld_waddr  = I2'($urandom_range(0, 15));
            b_ld_wdata  = $urandom;
            b_rd_en     = 1'b1;
            b_rd_addr1  = I2'($urandom_range(0, 15));
            b_rd_addr2  = (k % 4 == 0) ? b_alu_waddr : I2'($urandom_range(0, 15));
            e1 = model_read(b_rd_addr1);
            e2 = model_read(b_rd_addr2);
            model_write();
            cyc();
            check($sformatf("w_rand%0d_d1", k), b_d1, e1);
            check($sformatf("w_rand%0d_d2", k), b_d2, e2);
        end

        // Out-of-range index 13 and the last valid index 11.
        idle_b();
        b_alu_we = 1'b1; b_alu_waddr = 4'd13; b_alu_wdata = 32'hDEADBEEF;
        b_ld_we = 1'b1; b_ld_waddr = 4'd11; b_ld_wdata = 32'hCAFEF00D;
        b_sb_set = 1'b1; b_sb_addr = 4'd13;
        b_rd_en = 1'b1; b_rd_addr1 = 4'd13; b_rd_addr2 = 4'd11;
        cyc();
        check("w_oor_byp_d1", b_d1, 32'h0);
        check("w_last_byp_d2", b_d2, 32'hCAFEF00D);
        idle_b();
        b_rd_en = 1'b1; b_rd_addr1 = 4'd13; b_rd_addr2 = 4'd11;
        #1;
        check("w_oor_busy", 32'(b_b1), 32'h0);
        cyc();
        check("w_oor_st_d1", b_d1, 32'h0);
        check("w_last_st_d2", b_d2, 32'hCAFEF00D);
        check("w_valid", 32'(b_v), 32'h1);
        idle_b();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_file_pipe
